// File: rtl/addsub_flag_unit.sv
// Two-stage pipelined 32-bit adder/subtractor with Z/V/N flags for the branch/set comparer.
// The carry chain is split at bit 16; the low half is summed on accept, the high half and flags on advance.
module addsub_flag_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic [2:0]  ctrl_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Z,
  output logic        V,
  output logic        N,
  output logic [2:0]  ctrl_out
);

  logic        s1_valid;
  logic [15:0] s1_lo;
  logic        s1_c16;
  logic [15:0] s1_a_hi;
  logic [15:0] s1_b_hi;
  logic [2:0]  s1_ctrl;
  logic        s2_valid;

  logic        s2_take;
  logic        s1_move;
  logic        accept;
  logic [31:0] b_eff;
  logic [16:0] lo_sum;
  logic [16:0] hi_sum;
  logic [31:0] sum;
  logic        v_next;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    s2_take  = !s2_valid || out_ready;
    s1_move  = s1_valid && s2_take;
    in_ready = !s1_valid || s2_take;
    accept   = in_valid && in_ready;

    b_eff  = sub ? ~b : b;
    lo_sum = {1'b0, a[15:0]} + {1'b0, b_eff[15:0]} + {16'd0, sub};
    hi_sum = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {16'd0, s1_c16};
    sum    = {hi_sum[15:0], s1_lo};
    // Overflow: operands share a sign and the wrapped sum does not.
    v_next = (s1_a_hi[15] == s1_b_hi[15]) && (sum[31] != s1_a_hi[15]);
  end

  assign out_valid = s2_valid;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c16   <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_ctrl  <= '0;
    end else begin
      if (flush)        s1_valid <= 1'b0;
      else if (accept)  s1_valid <= 1'b1;
      else if (s1_move) s1_valid <= 1'b0;

      if (accept) begin
        s1_lo   <= lo_sum[15:0];
        s1_c16  <= lo_sum[16];
        s1_a_hi <= a[31:16];
        s1_b_hi <= b_eff[31:16];
        s1_ctrl <= ctrl_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      result   <= '0;
      Z        <= 1'b0;
      V        <= 1'b0;
      N        <= 1'b0;
      ctrl_out <= '0;
    end else begin
      if (flush)        s2_valid <= 1'b0;
      else if (s2_take) s2_valid <= s1_move;

      // Output registers only change when a transaction moves up, so they hold under backpressure.
      if (s1_move) begin
        result   <= sum;
        Z        <= (sum == 32'd0);
        V        <= v_next;
        N        <= sum[31] ^ v_next;
        ctrl_out <= s1_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_addsub_flag_unit.sv
// Self-checking bench for addsub_flag_unit: directed vector table, backpressure/flush/reset
// sequences, and randomized traffic against a signed-arithmetic reference model.
module tb_addsub_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [2:0]  ctrl_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        Z;
  logic        V;
  logic        N;
  logic [2:0]  ctrl_out;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_flag_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .ctrl_in   (ctrl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Z         (Z),
    .V         (V),
    .N         (N),
    .ctrl_out  (ctrl_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [2:0]  ctrl;
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        n;
    logic [2:0]  c;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed arithmetic in 64 bits, then derive flags from the definitions.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic [2:0] c);
    exp_t   e;
    longint sx;
    longint sy;
    longint exact;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    exact = s ? (sx - sy) : (sx + sy);
    e.r   = exact[31:0];
    e.v   = (exact != longint'($signed(e.r)));
    e.n   = (exact < 0);
    e.z   = (e.r == 32'd0);
    e.c   = c;
    return e;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    ctrl_in  = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, " result"},    result, 32'd0);
    check({tag, " flags"},     {29'd0, Z, V, N}, 32'd0);
    check({tag, " ctrl_out"},  {29'd0, ctrl_out}, 32'd0);
  endtask

  vec_t vecs[10];
  exp_t exp_q[$];

  initial begin
    exp_t e;
    exp_t held;
    logic hold_pending;
    int   idx;
    int   next_exp;
    int   cyc;

    vecs[0] = '{32'd5,        32'd5, 1'b1, 3'b101, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'd1, 1'b1, 3'b111, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{32'd3,        32'd7, 1'b1, 3'b001, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_FFFF, 32'd1, 1'b0, 3'b100, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h0001_0000, 32'd1, 1'b1, 3'b011, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'd0,        32'd0, 1'b1, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 3'b000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 3'b101, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'd0,        32'h8000_0000, 1'b1, 3'b010, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    // Reset state
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, each checked for the two-edge latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
      sub      = vecs[i].sub;
      ctrl_in  = vecs[i].ctrl;
      #1;
      check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("vec%0d early out_valid", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d result", i), result, vecs[i].r);
      check($sformatf("vec%0d ZVN", i), {29'd0, Z, V, N},
            {29'd0, vecs[i].z, vecs[i].v, vecs[i].n});
      check($sformatf("vec%0d ctrl_out", i), {29'd0, ctrl_out}, {29'd0, vecs[i].ctrl});
    end
    @(negedge clk);

    // Backpressure: four inputs with results 1..4, out_ready low for four cycles
    out_ready = 1'b0;
    idx       = 1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      a        = idx;
      b        = 32'd0;
      sub      = 1'b0;
      ctrl_in  = 3'(idx);
      #1;
      if (c >= 2) begin
        check($sformatf("bp in_ready cyc%0d", c), {31'd0, in_ready}, 32'd0);
        check($sformatf("bp held result cyc%0d", c), result, 32'd1);
        check($sformatf("bp held valid cyc%0d", c), {31'd0, out_valid}, 32'd1);
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    check("bp accepts before stall", idx, 3);
    out_ready = 1'b1;
    next_exp  = 1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx <= 4);
      a        = idx;
      ctrl_in  = 3'(idx);
      #1;
      check($sformatf("bp drain valid cyc%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp drain result cyc%0d", c), result, 32'(next_exp));
      next_exp++;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("bp empty after drain", {31'd0, out_valid}, 32'd0);

    // Flush with two transactions in flight; an offer in the flush cycle is dropped
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a        = 32'h100 + c;
      b        = 32'd1;
      @(negedge clk);
    end
    flush = 1'b1;
    a     = 32'h200;
    @(negedge clk);
    idle_inputs();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("flush out_valid cyc%0d", c), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle with two transactions in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a        = 32'h300 + c;
      b        = 32'd7;
      ctrl_in  = 3'b111;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    // Randomized traffic against the reference model
    hold_pending = 1'b0;
    held         = '0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      case ($urandom_range(3, 0))
        0:       a = 32'h8000_0000 - 32'($urandom_range(1, 0));
        1:       a = 32'($urandom_range(2, 0)) - 32'd1;
        default: a = $urandom;
      endcase
      b       = ($urandom_range(1, 0) != 0) ? $urandom : 32'($urandom_range(2, 0)) - 32'd1;
      sub     = $urandom_range(1, 0);
      ctrl_in = 3'($urandom_range(7, 0));
      #1;
      if (hold_pending) begin
        check("rand hold valid", {31'd0, out_valid}, 32'd1);
        check("rand hold result", result, held.r);
        check("rand hold flags", {29'd0, Z, V, N}, {29'd0, held.z, held.v, held.n});
      end
      hold_pending = out_valid && !out_ready;
      held         = '{result, Z, V, N, ctrl_out};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand unexpected output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand result", result, e.r);
          check("rand ZVN", {29'd0, Z, V, N}, {29'd0, e.z, e.v, e.n});
          check("rand ctrl_out", {29'd0, ctrl_out}, {29'd0, e.c});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, ctrl_in));
      @(negedge clk);
    end

    // Drain with a bounded cycle budget
    idle_inputs();
    out_ready = 1'b1;
    cyc       = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        check("drain result", result, e.r);
        check("drain ZVN", {29'd0, Z, V, N}, {29'd0, e.z, e.v, e.n});
      end
      cyc++;
      @(negedge clk);
    end
    check("drain leftover", exp_q.size(), 0);
    #1;
    check("drain final out_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
